opctrl_vc: RTL and testbench

Parametrised router output controller, successor to the two-slot polarity output stage. Per output port, it accepts one granted input among NUM_IN directions and stores the flit in one of two polarity virtual-channel FIFOs, each VC_DEPTH deep. During the opposite polarity it drains the other VC towards the next hop under receive_output back-pressure. It returns one-hot clear strobes to the input buffers and reports per-VC occupancy.

---
 rtl/noc_pkg.sv | 19 +
 rtl/opctrl_vc_if.sv | 34 +++
 rtl/vc_fifo.sv | 75 +++++++
 rtl/opctrl_vc.sv | 132 +++++++++++++
 tb/tb_opctrl_vc.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC constants: direction indices, direction count, flit width
package noc_pkg;

  localparam int NUM_DIR = 5;

  localparam int DIR_PE = 0;
  localparam int DIR_S  = 1;
  localparam int DIR_N  = 2;
  localparam int DIR_E  = 3;
  localparam int DIR_W  = 4;

  localparam int FLIT_W = 64;

  // Pointer width for a circular buffer of the given depth (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/opctrl_vc_if.sv
// rtl/opctrl_vc_if.sv - output controller bus: grant/flit inputs, clear strobes, outgoing flit and status
interface opctrl_vc_if
  import noc_pkg::*;
#(
  parameter int DATA_W   = FLIT_W,
  parameter int NUM_IN   = NUM_DIR,
  parameter int VC_DEPTH = 2
);

  localparam int CNT_W = $clog2(VC_DEPTH + 1);

  logic                     polarity;
  logic [NUM_IN-1:0]        grant;
  logic [NUM_IN*DATA_W-1:0] data_in;
  logic                     receive_output;
  logic [DATA_W-1:0]        data_out;
  logic                     send_output;
  logic                     empty;
  logic [NUM_IN-1:0]        clear;
  logic [CNT_W-1:0]         occ_even;
  logic [CNT_W-1:0]         occ_odd;
  logic                     grant_err;

  modport master (
    output polarity, grant, data_in, receive_output,
    input  data_out, send_output, empty, clear, occ_even, occ_odd, grant_err
  );

  modport slave (
    input  polarity, grant, data_in, receive_output,
    output data_out, send_output, empty, clear, occ_even, occ_odd, grant_err
  );

endinterface

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - DATA_W x DEPTH circular buffer with push/pop, occupancy count and full/empty
module vc_fifo
  import noc_pkg::*;
#(
  parameter int DATA_W = FLIT_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointers wrap at DEPTH-1 so non-power-of-two depths work; count tracks push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state; reset returns the buffer to empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flit storage is deliberately not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/opctrl_vc.sv
// rtl/opctrl_vc.sv - two-polarity VC output controller; OPCTRL_GRANT_CHECK_EN rejects multi-bit grants
module opctrl_vc
  import noc_pkg::*;
#(
  parameter int DATA_W   = FLIT_W,
  parameter int NUM_IN   = NUM_DIR,
  parameter int VC_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  opctrl_vc_if.slave     bus
);

  localparam int CNT_W = $clog2(VC_DEPTH + 1);

  logic              wvc, rvc;
  logic [NUM_IN-1:0] gsel;
  logic              push, pop;
  logic [DATA_W-1:0] push_data;

  logic [1:0]        vc_push, vc_pop, vc_full, vc_empty;
  logic [DATA_W-1:0] vc_head  [2];
  logic [CNT_W-1:0]  vc_count [2];

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              send_output_q, send_output_d;

  // The polarity VC being written is never the one being read.
  assign wvc = bus.polarity;
  assign rvc = ~bus.polarity;

`ifdef OPCTRL_GRANT_CHECK_EN
  logic grant_multi;
  logic grant_err_q, grant_err_d;

  assign grant_multi = (bus.grant & (bus.grant - NUM_IN'(1))) != '0;
  assign gsel        = grant_multi ? '0 : bus.grant;

  // Sticky flag: any multi-bit grant is remembered until reset.
  always_comb begin
    grant_err_d = grant_err_q | grant_multi;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_err_q <= 1'b0;
    end else begin
      grant_err_q <= grant_err_d;
    end
  end

  assign bus.grant_err = grant_err_q;

`ifndef SYNTHESIS
  // Simulation notice when an illegal grant is rejected.
  always @(posedge clk) begin
    if (reset && grant_multi) begin
      $display("opctrl_vc: multi-bit grant %b rejected", bus.grant);
    end
  end
`endif
`else
  // Isolate the lowest set bit so an accidental multi-bit grant still serves one input.
  assign gsel          = bus.grant & (~bus.grant + NUM_IN'(1));
  assign bus.grant_err = 1'b0;
`endif

  assign push = (|gsel) && !vc_full[wvc];
  assign pop  = bus.receive_output && !vc_empty[rvc];

  // Select the granted input slice for the write VC.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gsel[i]) begin
        push_data = bus.data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Route push/pop to the VC matching the current polarity.
  always_comb begin
    vc_push = '0;
    vc_pop  = '0;
    vc_push[wvc] = push;
    vc_pop[rvc]  = pop;
  end

  for (genvar v = 0; v < 2; v++) begin : g_vc
    vc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (VC_DEPTH),
      .CNT_W  (CNT_W)
    ) u_vc (
      .clk       (clk),
      .reset     (reset),
      .push      (vc_push[v]),
      .push_data (push_data),
      .pop       (vc_pop[v]),
      .head      (vc_head[v]),
      .count     (vc_count[v]),
      .full      (vc_full[v]),
      .empty     (vc_empty[v])
    );
  end

  // Outgoing flit holds its last value whenever nothing is sent.
  always_comb begin
    data_out_d    = pop ? vc_head[rvc] : data_out_q;
    send_output_d = pop;
  end

  // Registered output stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_q    <= '0;
      send_output_q <= 1'b0;
    end else begin
      data_out_q    <= data_out_d;
      send_output_q <= send_output_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.send_output = send_output_q;
  assign bus.clear       = push ? gsel : '0;
  assign bus.empty       = !vc_full[wvc];
  assign bus.occ_even    = vc_count[0];
  assign bus.occ_odd     = vc_count[1];

endmodule

// File: tb/tb_opctrl_vc.sv
// tb/tb_opctrl_vc.sv - randomized scoreboard bench for opctrl_vc against a queue-based model
module tb_opctrl_vc;
  import noc_pkg::*;

  localparam int DATA_W   = 64;
  localparam int NUM_IN   = 5;
  localparam int VC_DEPTH = 2;

  typedef struct {
    logic        send;
    logic [63:0] data;
    int          occ0;
    int          occ1;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  opctrl_vc_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .VC_DEPTH(VC_DEPTH)) bus ();

  opctrl_vc #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .VC_DEPTH(VC_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t        sb[$];
  logic [63:0] vcq0[$];
  logic [63:0] vcq1[$];
  logic [63:0] last_data = '0;
  logic        err_m = 1'b0;
  logic [63:0] din [NUM_IN];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, check combinational outputs, advance the model.
  task automatic step(input logic pol, input logic [NUM_IN-1:0] g, input logic recv, input logic rn);
    logic [NUM_IN-1:0] sel;
    logic              ful;
    logic              found;
    int                wn;
    exp_t              e;
    @(negedge clk);
    reset              = rn;
    bus.polarity       = pol;
    bus.grant          = g;
    bus.receive_output = recv;
    for (int i = 0; i < NUM_IN; i++) bus.data_in[i*DATA_W +: DATA_W] = din[i];
    #1;
    e.send = 1'b0;
    if (!rn) begin
      vcq0.delete();
      vcq1.delete();
      last_data = '0;
      err_m     = 1'b0;
    end else begin
      wn  = pol ? vcq1.size() : vcq0.size();
      ful = (wn >= VC_DEPTH);
      sel = '0;
`ifdef OPCTRL_GRANT_CHECK_EN
      if ($countones(g) > 1) err_m = 1'b1;
      else sel = g;
`else
      found = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (g[i] && !found) begin
          sel[i] = 1'b1;
          found  = 1'b1;
        end
      end
`endif
      if (ful) sel = '0;
      chk("clear", 64'(bus.clear), 64'(sel));
      chk("empty", 64'(bus.empty), 64'(!ful));
      if (recv) begin
        if (!pol && vcq1.size() > 0) begin
          last_data = vcq1.pop_front();
          e.send = 1'b1;
        end else if (pol && vcq0.size() > 0) begin
          last_data = vcq0.pop_front();
          e.send = 1'b1;
        end
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel[i]) begin
          if (pol) vcq1.push_back(din[i]);
          else     vcq0.push_back(din[i]);
        end
      end
    end
    e.data = last_data;
    e.occ0 = vcq0.size();
    e.occ1 = vcq1.size();
    e.err  = err_m;
    sb.push_back(e);
  endtask

  // Monitor: after every edge compare registered outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("send_output", 64'(bus.send_output), 64'(e.send));
        chk("data_out", bus.data_out, e.data);
        chk("occ_even", 64'(bus.occ_even), 64'(e.occ0));
        chk("occ_odd", 64'(bus.occ_odd), 64'(e.occ1));
        chk("grant_err", 64'(bus.grant_err), 64'(e.err));
      end
    end
  end

  initial begin
    logic              pol;
    logic [NUM_IN-1:0] g;
    int                r;
    bus.polarity       = 1'b0;
    bus.grant          = '0;
    bus.data_in        = '0;
    bus.receive_output = 1'b0;
    for (int i = 0; i < NUM_IN; i++) din[i] = '0;

    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);

    din[DIR_N] = 64'hA5;
    step(0, 5'b00100, 0, 1);
    step(1, 5'b00000, 1, 1);

    din[DIR_S] = 64'd1;
    step(0, 5'b00010, 0, 1);
    step(1, 5'b00000, 0, 1);
    din[DIR_S] = 64'd2;
    step(0, 5'b00010, 0, 1);
    step(1, 5'b00000, 0, 1);
    din[DIR_S] = 64'd3;
    step(0, 5'b00010, 0, 1);
    step(1, 5'b00000, 1, 1);
    step(0, 5'b00000, 0, 1);
    step(1, 5'b00000, 1, 1);
    step(0, 5'b00000, 0, 1);

    din[DIR_PE] = 64'h1111;
    din[DIR_S]  = 64'h2222;
    step(0, 5'b00011, 0, 1);
    step(1, 5'b00000, 1, 1);
    step(0, 5'b00100, 0, 1);
    step(1, 5'b00000, 1, 1);

    for (int i = 0; i < NUM_IN; i++) din[i] = {$urandom, $urandom};
    step(0, 5'b00001, 0, 1);
    step(1, 5'b00010, 0, 1);
    step(0, 5'b00000, 0, 0);
    step(1, 5'b00000, 1, 1);
    step(0, 5'b00000, 1, 1);
    step(1, 5'b00000, 1, 1);

    pol = 1'b0;
    for (int n = 0; n < 800; n++) begin
      pol = ($urandom_range(0, 7) == 0) ? 1'($urandom_range(0, 1)) : ~pol;
      r = $urandom_range(0, 7);
      if (r < 2)      g = '0;
      else if (r < 6) g = NUM_IN'(1) << $urandom_range(0, NUM_IN - 1);
      else            g = NUM_IN'($urandom);
      for (int i = 0; i < NUM_IN; i++) din[i] = {$urandom, $urandom};
      step(pol, g, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) != 0));
    end

    step(0, '0, 1, 1);
    step(1, '0, 1, 1);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
